// File: rtl/synapse_weight_gate.sv
// synapse_weight_gate: holds one 2-bit weight per synapse, loaded serially
// through a valid/ready handshake, and gates the weights with an incoming spike
// vector to feed an N_STAGE-stage adder tree.
// Optional feature: define SYN_READBACK_EN to add a registered weight readback
// port (rd_addr/rd_data).
module synapse_weight_gate #(
  parameter int unsigned N_STAGE = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [1:0]                    w_data,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [(2**N_STAGE)-1:0]       spikes,
  input  logic                          spike_valid,
  output logic [(2*(2**N_STAGE))-1:0]   wx,
  output logic                          wx_valid,
`ifdef SYN_READBACK_EN
  input  logic [N_STAGE-1:0]            rd_addr,
  output logic [1:0]                    rd_data,
`endif
  output logic                          loaded
);

  localparam int unsigned N_SYN = 2**N_STAGE;
  localparam logic [N_STAGE-1:0] CntLast = N_STAGE'(N_SYN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReady
  } state_e;

  state_e                    r_state;
  logic [N_STAGE-1:0]        r_cnt;
  logic [1:0]                r_weight [N_SYN];
  logic [(2*N_SYN)-1:0]      r_wx;
  logic                      r_wx_valid;
  logic                      r_w_ready;
  logic                      r_loaded;
  logic [(2*N_SYN)-1:0]      w_gated;

  // Spike gating: each synapse passes its weight only when its spike bit is set.
  always_comb begin
    w_gated = '0;
    for (int i = 0; i < N_SYN; i++) begin
      w_gated[2*i +: 2] = spikes[i] ? r_weight[i] : 2'b00;
    end
  end

  // Control FSM with weight storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_wx       <= '0;
      r_wx_valid <= 1'b0;
      r_w_ready  <= 1'b0;
      r_loaded   <= 1'b0;
      for (int i = 0; i < N_SYN; i++) begin
        r_weight[i] <= 2'b00;
      end
    end else begin
      r_wx_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (load_start) begin
            r_state   <= StLoad;
            r_cnt     <= '0;
            r_w_ready <= 1'b1;
            r_loaded  <= 1'b0;
          end
        end
        StLoad: begin
          // load_start is ignored here so a running load never restarts.
          if (w_valid && r_w_ready) begin
            r_weight[r_cnt] <= w_data;
            if (r_cnt == CntLast) begin
              // Counter parks at the last index instead of wrapping.
              r_state   <= StReady;
              r_w_ready <= 1'b0;
              r_loaded  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StReady: begin
          // Gating uses the weights held this cycle, even if a reload starts now.
          if (spike_valid) begin
            r_wx       <= w_gated;
            r_wx_valid <= 1'b1;
          end
          if (load_start) begin
            r_state   <= StLoad;
            r_cnt     <= '0;
            r_w_ready <= 1'b1;
            r_loaded  <= 1'b0;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_w_ready <= 1'b0;
          r_loaded  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYN_READBACK_EN
  logic [1:0] r_rd_data;

  // Registered weight readback, usable in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= 2'b00;
    end else begin
      r_rd_data <= r_weight[rd_addr];
    end
  end

  assign rd_data = r_rd_data;
`endif

  assign w_ready  = r_w_ready;
  assign wx       = r_wx;
  assign wx_valid = r_wx_valid;
  assign loaded   = r_loaded;

endmodule

// File: tb/tb_synapse_weight_gate.sv
// Directed self-checking bench for synapse_weight_gate (N_STAGE = 5, 32 synapses).
module tb_synapse_weight_gate;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic [1:0]  w_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] spikes;
  logic        spike_valid;
  logic [63:0] wx;
  logic        wx_valid;
  logic        loaded;
`ifdef SYN_READBACK_EN
  logic [4:0]  rd_addr;
  logic [1:0]  rd_data;
`endif

  int n_vec;
  int n_err;
  logic [1:0] m_w [32];

  synapse_weight_gate #(
    .N_STAGE(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .spikes     (spikes),
    .spike_valid(spike_valid),
    .wx         (wx),
    .wx_valid   (wx_valid),
`ifdef SYN_READBACK_EN
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
`endif
    .loaded     (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full reload of m_w; optionally stalls w_valid for stall_len cycles after symbol stall_at.
  task automatic do_load(input int stall_at, input int stall_len);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_enter_w_ready", {63'd0, w_ready}, 64'd1);
    check("load_enter_loaded", {63'd0, loaded}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      w_valid = 1'b1;
      w_data  = m_w[i];
      tick();
      if (i == stall_at) begin
        w_valid = 1'b0;
        w_data  = 2'b01;
        for (int s = 0; s < stall_len; s++) begin
          tick();
        end
        check("stall_cnt", {59'd0, dut.r_cnt}, 64'd11);
        check("stall_w_ready", {63'd0, w_ready}, 64'd1);
        check("stall_loaded", {63'd0, loaded}, 64'd0);
      end
    end
    w_valid = 1'b0;
    check("load_done_loaded", {63'd0, loaded}, 64'd1);
    check("load_done_w_ready", {63'd0, w_ready}, 64'd0);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    load_start  = 1'b0;
    w_data      = 2'b00;
    w_valid     = 1'b0;
    spikes      = '0;
    spike_valid = 1'b0;
`ifdef SYN_READBACK_EN
    rd_addr     = '0;
`endif

    // Reset state
    tick();
    tick();
    check("rst_loaded", {63'd0, loaded}, 64'd0);
    check("rst_wx_valid", {63'd0, wx_valid}, 64'd0);
    check("rst_w_ready", {63'd0, w_ready}, 64'd0);
    check("rst_wx", wx, 64'd0);

    // Reset beats load_start in the same cycle
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    rst        = 1'b0;
    check("rst_prio_w_ready", {63'd0, w_ready}, 64'd0);
    tick();
    check("idle_no_load", {63'd0, w_ready}, 64'd0);

    // Full load of all-ones weights
    for (int i = 0; i < 32; i++) m_w[i] = 2'b11;
    do_load(-1, 0);
    tick();
    check("ready_w_ready_low", {63'd0, w_ready}, 64'd0);
    check("ready_loaded_hold", {63'd0, loaded}, 64'd1);
    spikes      = 32'hFFFF_FFFF;
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    check("ones_wx", wx, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ones_wx_valid", {63'd0, wx_valid}, 64'd1);
    spikes = 32'h0;
    tick();
    check("strobe_one_cycle", {63'd0, wx_valid}, 64'd0);
    check("wx_held", wx, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reload weights i%4 with a 5-cycle stall after symbol 10
    for (int i = 0; i < 32; i++) m_w[i] = 2'(i % 4);
    do_load(10, 5);
    spikes      = 32'h0000_00FF;
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    check("gate_ff_wx", wx, 64'h0000_0000_0000_E4E4);
    check("gate_ff_wx_valid", {63'd0, wx_valid}, 64'd1);
`ifdef SYN_READBACK_EN
    rd_addr = 5'd7;
    tick();
    check("readback_7", {62'd0, rd_data}, 64'd3);
`endif

    // Back-to-back spikes, one result per cycle
    spikes      = 32'hFFFF_FFFF;
    spike_valid = 1'b1;
    tick();
    check("b2b0_wx", wx, 64'hE4E4_E4E4_E4E4_E4E4);
    check("b2b0_valid", {63'd0, wx_valid}, 64'd1);
    spikes = 32'h0000_000F;
    tick();
    check("b2b1_wx", wx, 64'h0000_0000_0000_00E4);
    check("b2b1_valid", {63'd0, wx_valid}, 64'd1);
    spikes = 32'hF000_0000;
    tick();
    spike_valid = 1'b0;
    check("b2b2_wx", wx, 64'hE400_0000_0000_0000);
    check("b2b2_valid", {63'd0, wx_valid}, 64'd1);
    tick();
    check("b2b_end_valid", {63'd0, wx_valid}, 64'd0);
    check("b2b_end_wx", wx, 64'hE400_0000_0000_0000);

    // load_start together with spike_valid in READY
    spikes      = 32'hFFFF_FFFF;
    spike_valid = 1'b1;
    load_start  = 1'b1;
    tick();
    spike_valid = 1'b0;
    load_start  = 1'b0;
    check("simul_wx", wx, 64'hE4E4_E4E4_E4E4_E4E4);
    check("simul_valid", {63'd0, wx_valid}, 64'd1);
    check("simul_loaded", {63'd0, loaded}, 64'd0);
    check("simul_w_ready", {63'd0, w_ready}, 64'd1);

    // load_start while loading must not restart the counter
    w_data = 2'b10;
    for (int i = 0; i < 5; i++) begin
      w_valid = 1'b1;
      tick();
    end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    w_valid    = 1'b0;
    check("load_start_ignored_cnt", {59'd0, dut.r_cnt}, 64'd6);

    // spike_valid during LOAD is ignored
    spike_valid = 1'b1;
    spikes      = 32'hFFFF_FFFF;
    tick();
    spike_valid = 1'b0;
    check("load_spike_valid", {63'd0, wx_valid}, 64'd0);
    check("load_spike_wx", wx, 64'hE4E4_E4E4_E4E4_E4E4);
    for (int i = 0; i < 10; i++) begin
      w_valid = 1'b1;
      tick();
    end
    w_valid = 1'b0;
    check("partial_loaded", {63'd0, loaded}, 64'd0);

    // Reset after 16 accepts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_loaded", {63'd0, loaded}, 64'd0);
    check("midrst_wx", wx, 64'd0);
    check("midrst_valid", {63'd0, wx_valid}, 64'd0);
    check("midrst_w_ready", {63'd0, w_ready}, 64'd0);
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    check("idle_spike_valid", {63'd0, wx_valid}, 64'd0);
    check("idle_spike_wx", wx, 64'd0);

    // Fresh load, weight = i/8
    for (int i = 0; i < 32; i++) m_w[i] = 2'(i >> 3);
    do_load(-1, 0);
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    check("reload_wx", wx, 64'hFFFF_AAAA_5555_0000);
    check("reload_valid", {63'd0, wx_valid}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
